lcd_bus_responder: RTL and testbench

- Synchronous model of an HD44780-compatible 2x16 character LCD, sitting on the far end of the E/RS/RW/DATA bus.
- Samples bus strobes and decodes instructions and data writes.
- Keeps the address counter, display flags and a 32-byte visible DDRAM shadow.
- Exposes the shadow through a registered read port so bench logic and on-board checkers can compare against expected screen contents.

---
 rtl/lcd_bus_responder.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-style 2x16 LCD bus responder: samples the E/RS/RW/DATA bus, decodes
// instructions and data writes, and keeps a 32-byte visible DDRAM shadow.
module lcd_bus_responder #(
    parameter int CMD_BUSY    = 0,
    parameter int CLEAR_EXTRA = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    input  logic       clr_overrun,
    output logic [7:0] rd_data,
    output logic [6:0] addr_counter,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       two_line,
    output logic       init_done,
    output logic       busy,
    output logic       overrun,
    output logic       write_pulse
);

    localparam logic [15:0] CMD_LOAD = (CMD_BUSY > 0) ? 16'(CMD_BUSY - 1) : '0;
    localparam logic [15:0] CLR_LOAD = 16'(32 + CLEAR_EXTRA - 1);
    localparam logic [7:0]  SPACE    = 8'h20;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t      state, state_next;
    logic        e1, e2, e3;
    logic [9:0]  bus1, bus2, bus3;
    logic [15:0] busy_cnt;
    logic [4:0]  fill_ptr;
    logic        fill_we;
    logic        cgram_mode;
    logic [7:0]  shadow [32];

    logic       rs3, rw3;
    logic [7:0] d3;
    logic       strobe, accept, inst, dwrite, clear_cmd, overrun_set;
    logic       ac_valid;
    logic [4:0] ac_index;

    assign rs3         = bus3[9];
    assign rw3         = bus3[8];
    assign d3          = bus3[7:0];
    assign strobe      = e3 & ~e2;
    assign accept      = strobe & ~rw3 & ~busy;
    assign inst        = accept & ~rs3;
    assign dwrite      = accept & rs3;
    assign clear_cmd   = inst & (d3 == 8'h01);
    assign overrun_set = strobe & ~rw3 & rs3 & busy;

    // Only 0x00-0x0F (line 0) and 0x40-0x4F (line 1) are visible
    assign ac_valid = (addr_counter[6:4] == 3'b000) || (addr_counter[6:4] == 3'b100);
    assign ac_index = {addr_counter[6], addr_counter[3:0]};

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            case (a)
                7'h27:   return 7'h40;
                7'h67:   return 7'h00;
                default: return a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h00:   return 7'h67;
                7'h40:   return 7'h27;
                default: return a - 7'd1;
            endcase
        end
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fill_we    = 1'b0;
        case (state)
            S_IDLE: if (clear_cmd) state_next = S_FILL;
            S_FILL: begin
                fill_we = 1'b1;
                if (fill_ptr == 5'd31) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e1   <= 1'b0;
            e2   <= 1'b0;
            e3   <= 1'b0;
            bus1 <= '0;
            bus2 <= '0;
            bus3 <= '0;
        end else begin
            e1   <= lcd_e;
            e2   <= e1;
            e3   <= e2;
            bus1 <= {lcd_rs, lcd_rw, lcd_data};
            bus2 <= bus1;
            bus3 <= bus2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_counter <= '0;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            entry_inc    <= 1'b1;
            two_line     <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            busy_cnt     <= '0;
            cgram_mode   <= 1'b0;
            overrun      <= 1'b0;
            write_pulse  <= 1'b0;
        end else begin
            write_pulse <= 1'b0;
            if (busy) begin
                if (busy_cnt == '0) busy <= 1'b0;
                else                busy_cnt <= busy_cnt - 16'd1;
            end
            if (inst) begin
                if (CMD_BUSY > 0) begin
                    busy     <= 1'b1;
                    busy_cnt <= CMD_LOAD;
                end
                casez (d3)
                    8'b1???????: begin
                        addr_counter <= d3[6:0];
                        cgram_mode   <= 1'b0;
                    end
                    8'b01??????: cgram_mode <= 1'b1;
                    8'b001?????: begin
                        two_line  <= d3[3];
                        init_done <= init_done | d3[4];
                    end
                    8'b0001????: if (!d3[3]) addr_counter <= ac_step(addr_counter, d3[2]);
                    8'b00001???: begin
                        display_on <= d3[2];
                        cursor_on  <= d3[1];
                        blink_on   <= d3[0];
                    end
                    8'b000001??: entry_inc <= d3[1];
                    8'b0000001?: begin
                        addr_counter <= '0;
                        cgram_mode   <= 1'b0;
                    end
                    8'b00000001: begin
                        addr_counter <= '0;
                        entry_inc    <= 1'b1;
                        cgram_mode   <= 1'b0;
                        busy         <= 1'b1;
                        busy_cnt     <= CLR_LOAD;
                    end
                    default: ;
                endcase
            end
            if (dwrite) begin
                write_pulse <= 1'b1;
                if (!cgram_mode) addr_counter <= ac_step(addr_counter, entry_inc);
                if (CMD_BUSY > 0) begin
                    busy     <= 1'b1;
                    busy_cnt <= CMD_LOAD;
                end
            end
            if (overrun_set)      overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    // Fill and bus writes never coincide: the fill runs only while busy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) shadow[i] <= SPACE;
            fill_ptr <= '0;
            rd_data  <= '0;
        end else begin
            fill_ptr <= fill_we ? fill_ptr + 5'd1 : '0;
            if (fill_we)                             shadow[fill_ptr] <= SPACE;
            else if (dwrite && !cgram_mode && ac_valid) shadow[ac_index] <= d3;
            rd_data <= shadow[rd_addr];
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed-vector bench for lcd_bus_responder: drives slow E strobes on the
// LCD bus and compares flags, AC and shadow contents against hand values.
module tb_lcd_bus_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b1;
    logic [7:0] lcd_data = '0;
    logic [4:0] rd_addr = '0;
    logic       clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic [6:0] addr_counter;
    logic       display_on, cursor_on, blink_on, entry_inc, two_line;
    logic       init_done, busy, overrun, write_pulse;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    logic busy_seen = 1'b0;

    lcd_bus_responder #(.CMD_BUSY(0), .CLEAR_EXTRA(4)) dut (
        .clock(clock), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data(lcd_data), .rd_addr(rd_addr),
        .clr_overrun(clr_overrun), .rd_data(rd_data), .addr_counter(addr_counter),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .two_line(two_line), .init_done(init_done),
        .busy(busy), .overrun(overrun), .write_pulse(write_pulse)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (write_pulse) pulse_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Returns on the negedge where E falls; bus values stay driven
    task automatic bus_strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clock);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        repeat (2) @(negedge clock);
        lcd_e = 1'b1;
        repeat (4) @(negedge clock);
        lcd_e = 1'b0;
    endtask

    task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d);
        bus_strobe(rs, rw, d);
        repeat (4) @(negedge clock);
        lcd_rw = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] d);
        bus_write(1'b0, 1'b0, d);
    endtask

    task automatic dat(input logic [7:0] d);
        bus_write(1'b1, 1'b0, d);
    endtask

    task automatic read_shadow(input logic [4:0] a, output logic [7:0] v);
        @(negedge clock);
        rd_addr = a;
        @(negedge clock);
        v = rd_data;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("busy_drop", {31'd0, busy}, 32'd0);
    endtask

    task automatic clr_pulse();
        @(negedge clock);
        clr_overrun = 1'b1;
        @(negedge clock);
        clr_overrun = 1'b0;
    endtask

    task automatic check_all_space(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_shadow(5'(i), v);
            check(tag, {24'd0, v}, 32'h20);
        end
    endtask

    initial begin
        logic [7:0] v;
        int p0;
        int nb;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_rd_data", {24'd0, rd_data}, 32'h00);
        check("rst_ac", {25'd0, addr_counter}, 32'h00);
        check("rst_entry_inc", {31'd0, entry_inc}, 32'd1);
        check("rst_flags", {24'd0, display_on, cursor_on, blink_on, two_line,
                            init_done, busy, overrun, write_pulse}, 32'd0);
        reset = 1'b1;
        read_shadow(5'd5, v);
        check("rst_shadow5", {24'd0, v}, 32'h20);

        // Init sequence
        busy_seen = 1'b0;
        cmd(8'h38); cmd(8'h0C); cmd(8'h06);
        check("init_done", {31'd0, init_done}, 32'd1);
        check("two_line", {31'd0, two_line}, 32'd1);
        check("dcb", {29'd0, display_on, cursor_on, blink_on}, 32'b100);
        check("entry_inc", {31'd0, entry_inc}, 32'd1);
        check("never_busy", {31'd0, busy_seen}, 32'd0);

        // Line 0 writes
        p0 = pulse_cnt;
        cmd(8'h80); dat(8'h4B); dat(8'h4F); dat(8'h52);
        check("l0_pulses", pulse_cnt - p0, 32'd3);
        check("l0_ac", {25'd0, addr_counter}, 32'h03);
        read_shadow(5'd0, v); check("l0_e0", {24'd0, v}, 32'h4B);
        read_shadow(5'd1, v); check("l0_e1", {24'd0, v}, 32'h4F);
        read_shadow(5'd2, v); check("l0_e2", {24'd0, v}, 32'h52);

        // Line 1 writes and AC wrap points
        cmd(8'hC0);
        for (int i = 0; i < 16; i++) dat(8'h30 + 8'(i));
        check("l1_ac", {25'd0, addr_counter}, 32'h50);
        for (int i = 0; i < 16; i++) begin
            read_shadow(5'(16 + i), v);
            check("l1_entry", {24'd0, v}, 32'h30 + i);
        end
        dat(8'h99);
        check("ac_0x51", {25'd0, addr_counter}, 32'h51);
        cmd(8'hA7); dat(8'h97);
        check("wrap_27_40", {25'd0, addr_counter}, 32'h40);
        cmd(8'hE7); dat(8'h98);
        check("wrap_67_00", {25'd0, addr_counter}, 32'h00);
        read_shadow(5'd16, v); check("hidden_keep16", {24'd0, v}, 32'h30);
        read_shadow(5'd0, v);  check("hidden_keep0", {24'd0, v}, 32'h4B);

        // Cursor shift, decrement entry mode, home, CGRAM mode
        cmd(8'h10);
        check("shift_dec_00", {25'd0, addr_counter}, 32'h67);
        cmd(8'h14);
        check("shift_inc_67", {25'd0, addr_counter}, 32'h00);
        cmd(8'h04);
        check("entry_dec", {31'd0, entry_inc}, 32'd0);
        dat(8'h41);
        check("dec_wrap_00", {25'd0, addr_counter}, 32'h67);
        read_shadow(5'd0, v); check("dec_write", {24'd0, v}, 32'h41);
        cmd(8'h06); cmd(8'h02);
        check("home", {25'd0, addr_counter}, 32'h00);
        p0 = pulse_cnt;
        cmd(8'h40); dat(8'h77);
        check("cgram_pulse", pulse_cnt - p0, 32'd1);
        check("cgram_ac", {25'd0, addr_counter}, 32'h00);
        read_shadow(5'd0, v); check("cgram_noshadow", {24'd0, v}, 32'h41);
        cmd(8'h80);

        // Clear: exact busy length and full fill
        cmd(8'h04);
        bus_strobe(1'b0, 1'b0, 8'h01);
        nb = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (busy) nb++;
        end
        lcd_rw = 1'b1;
        check("clear_busy_cycles", nb, 32'd36);
        check("clear_ac", {25'd0, addr_counter}, 32'h00);
        check("clear_entry_inc", {31'd0, entry_inc}, 32'd1);
        check_all_space("clear_fill");

        // Overrun set by a data write while busy, then cleared
        p0 = pulse_cnt;
        cmd(8'h01);
        dat(8'h55);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_no_pulse", pulse_cnt - p0, 32'd0);
        wait_idle();
        read_shadow(5'd0, v); check("ovr_dropped", {24'd0, v}, 32'h20);
        check("ovr_ac", {25'd0, addr_counter}, 32'h00);
        clr_pulse();
        check("ovr_clear", {31'd0, overrun}, 32'd0);

        // Set and clear landing on the same cycle
        cmd(8'h01);
        clr_overrun = 1'b1;
        bus_strobe(1'b1, 1'b0, 8'h66);
        repeat (3) @(negedge clock);
        check("ovr_set_wins", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b0;
        @(negedge clock);
        check("ovr_held", {31'd0, overrun}, 32'd1);
        lcd_rw = 1'b1;
        wait_idle();
        clr_pulse();
        check("ovr_clear2", {31'd0, overrun}, 32'd0);

        // Idle reads on the bus change nothing
        p0 = pulse_cnt;
        busy_seen = 1'b0;
        repeat (50) bus_write(1'b1, 1'b1, 8'h00);
        check("idle_ac", {25'd0, addr_counter}, 32'h00);
        check("idle_flags", {26'd0, display_on, cursor_on, blink_on, entry_inc,
                             two_line, init_done}, 32'b100111);
        check("idle_overrun", {31'd0, overrun}, 32'd0);
        check("idle_pulses", pulse_cnt - p0, 32'd0);
        check("idle_busy", {31'd0, busy_seen}, 32'd0);
        read_shadow(5'd0, v); check("idle_shadow", {24'd0, v}, 32'h20);

        // Reset aborts a clear in progress
        cmd(8'hC0); dat(8'h5A);
        read_shadow(5'd16, v); check("pre_rst_write", {24'd0, v}, 32'h5A);
        bus_strobe(1'b0, 1'b0, 8'h01);
        repeat (13) @(negedge clock);
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ac2", {25'd0, addr_counter}, 32'h00);
        check("rst_rd_data2", {24'd0, rd_data}, 32'h00);
        check("rst_flags2", {28'd0, display_on, init_done, two_line, overrun}, 32'd0);
        lcd_rw = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check_all_space("rst_shadow");

        // Normal operation after re-init
        cmd(8'h38); cmd(8'h0C); cmd(8'h06);
        check("reinit_done", {31'd0, init_done}, 32'd1);
        cmd(8'h80); dat(8'h48);
        check("reinit_ac", {25'd0, addr_counter}, 32'h01);
        read_shadow(5'd0, v); check("reinit_write", {24'd0, v}, 32'h48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
